// File: rtl/hamming_74_pkg.sv
// Shared Hamming(7,4) types, bit-position constants and the syndrome helper,
// kept here so a future encoder computes parity the same way.
package hamming_74_pkg;

    typedef logic [7:1] codeword_t;
    typedef logic [3:0] data_t;
    typedef logic [2:0] syndrome_t;

    // Data positions listed LSB first, so a data_t reads {c7,c6,c5,c3}.
    localparam int DATA_POS [4] = '{3, 5, 6, 7};
    localparam int PAR_POS  [3] = '{1, 2, 4};

    // Syndrome bit j covers every position whose index has parity bit j set.
    function automatic syndrome_t calc_syndrome(codeword_t code);
        syndrome_t syn;
        syn = '0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 1; k <= 7; k++) begin
                if ((k & PAR_POS[j]) != 0) begin
                    syn[j] = syn[j] ^ code[k];
                end
            end
        end
        return syn;
    endfunction

endpackage

// File: rtl/hamming_74_correct.sv
// Combinational single-error corrector: flips the bit named by the syndrome
// and extracts the data bits. With PASS_THRU=1 nothing is flipped.
module hamming_74_correct
    import hamming_74_pkg::*;
#(
    parameter int PASS_THRU = 0
) (
    input  logic [7:1] code_i,
    input  logic [2:0] syndrome_i,
    output logic [3:0] data_o,
    output logic       corrected_o
);

    logic      flip_en;
    codeword_t fixed;

    assign flip_en     = (PASS_THRU == 0) && (syndrome_i != 3'd0);
    assign corrected_o = flip_en;

    always_comb begin
        fixed  = code_i;
        data_o = '0;
        for (int k = 1; k <= 7; k++) begin
            if (flip_en && (syndrome_i == 3'(k))) begin
                fixed[k] = ~code_i[k];
            end
        end
        for (int i = 0; i < 4; i++) begin
            data_o[i] = fixed[DATA_POS[i]];
        end
    end

endmodule

// File: rtl/hamming_74_decoder.sv
// Two-stage valid/ready Hamming(7,4) decoder. Defining HAMMING_ERR_CNT_EN adds
// a saturating corrected-error counter with err_count / err_count_clr ports.
module hamming_74_decoder
    import hamming_74_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PASS_THRU = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:1]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
`ifdef HAMMING_ERR_CNT_EN
    output logic [CNT_W-1:0] err_count,
    input  logic             err_count_clr,
`endif
    output logic             out_corrected
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic      s1_valid_q, s1_valid_d;
    codeword_t s1_code_q, s1_code_d;
    syndrome_t s1_syn_q, s1_syn_d;
    logic      s2_valid_q, s2_valid_d;
    data_t     s2_data_q, s2_data_d;
    syndrome_t s2_syn_q, s2_syn_d;
    logic      s2_corr_q, s2_corr_d;
    logic      s1_adv, s2_adv;
    data_t     fix_data;
    logic      fix_corr;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    hamming_74_correct #(
        .PASS_THRU   (PASS_THRU)
    ) u_correct (
        .code_i      (s1_code_q),
        .syndrome_i  (s1_syn_q),
        .data_o      (fix_data),
        .corrected_o (fix_corr)
    );

    // Payload registers only load on a real transfer, so in_code is ignored otherwise.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_corr_d  = s2_corr_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = calc_syndrome(in_code);
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = fix_data;
                s2_syn_d  = s1_syn_q;
                s2_corr_d = fix_corr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_corr_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_corr_q  <= s2_corr_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_data      = s2_data_q;
    assign out_syndrome  = s2_syn_q;
    assign out_corrected = s2_corr_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (err_count_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && out_corrected && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`endif

endmodule

// File: doc/hamming_74_decoder.md
Name: hamming_74_decoder

Overview:
Receive side of the Hamming(7,4) link. Takes 7-bit codewords, possibly corrupted by fault_injector, and computes the syndrome. Corrects any single-bit error and returns the 4 data bits with status flags. Two-stage valid/ready pipeline sits between fault_injector output and the LED/display logic.

Parameters:
CNT_W, 8, width of saturating corrected-error counter (optional feature)
PASS_THRU, 0, 1 = report syndrome but do not correct data

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  codeword present
in_ready  out  1  decoder can accept codeword this cycle
in_code  in  7  codeword, indexed [7:1]; parity at 1,2,4; data at 3,5,6,7
out_valid  out  1  decoded result present
out_ready  in  1  consumer accepts result this cycle
out_data  out  4  {bit7,bit6,bit5,bit3} after correction
out_syndrome  out  3  {s2,s1,s0}; nonzero = erroneous bit position
out_corrected  out  1  syndrome nonzero, bit flipped (forced 0 when PASS_THRU=1)
err_count  out  CNT_W  corrected-error count (only with HAMMING_ERR_CNT_EN)
err_count_clr  in  1  synchronous clear of err_count (only with HAMMING_ERR_CNT_EN)

Behaviour:
- Reset: decoder uses one clock, clk; reset is synchronous and active-high on rst. On rst=1 at a clk edge, both stage valids clear, out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, err_count=0. Any in-flight codewords are discarded. in_ready=1 in the first cycle after reset.
- Syndrome: s0=c1^c3^c5^c7; s1=c2^c3^c6^c7; s2=c4^c5^c6^c7.
- Stage 1 registers the codeword and syndrome. Stage 2 registers the corrected word, extracted data and flags.
- Correction: when syndrome=k≠0, flip bit k. Flipping a parity position (1,2,4) leaves the data unchanged, but out_corrected is still 1. Syndrome 0 means pass through.
- Double errors produce a miscorrection. This is accepted behaviour; nothing is flagged.
- Handshake: a transfer happens on a cycle where valid&&ready.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || s2 advances.
  - in_ready = stage-1 advance condition (combinational from out_ready).
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput is 1 word/cycle.
- Stall: while out_valid && !out_ready, all out_* stay stable and no data is lost. A full pipeline holds 2 words.
- Simultaneous accept and emit in the same cycle is legal; occupancy is unchanged.
- in_code is sampled only on an accepted cycle.

Optional Feature:
Macro HAMMING_ERR_CNT_EN.
- Defined: err_count and err_count_clr ports exist. err_count increments by 1 on every output transfer (out_valid&&out_ready) with out_corrected=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - err_count_clr has priority over an increment in the same cycle; the result is 0.
- Undefined: both ports are absent and no counter logic is generated.

Decomposition:
- Package hamming_74_pkg:
  - Constants for data/parity bit positions (DATA_POS = 3,5,6,7; PAR_POS = 1,2,4).
  - typedef codeword_t (logic [7:1]), data_t (logic [3:0]), syndrome_t (logic [2:0]).
  - Function calc_syndrome(codeword_t), shared with any future encoder.
- One sub-module, hamming_74_correct: combinational. Takes the codeword and syndrome and produces the corrected data and corrected flag. Instantiated in stage 2.

Test Plan:
- Clean word: data 4'b1011 encoded as 7'b1010101, out_ready=1 → 2 cycles later out_data=1011, syndrome=0, corrected=0.
- Single data error: 7'b1010001 (bit 3 flipped) → out_data=1011, syndrome=3, corrected=1. Repeat with 7'b0010101 (bit 7) → syndrome=7, out_data=1011.
- Parity error: 7'b1010100 (bit 1 flipped) → out_data=1011, syndrome=1, corrected=1.
- Backpressure: stream 4 words with out_ready=0 → in_ready drops after 2 accepts and out_* stay stable. Then raise out_ready → all 4 words appear in order with no loss or duplication.
- Reset mid-stream: assert rst with the pipeline full → next cycle out_valid=0, in_ready=1. No stale word appears afterwards.
- Counter (HAMMING_ERR_CNT_EN, CNT_W=2): 5 corrected words → err_count saturates at 3. Assert err_count_clr together with a corrected transfer → err_count=0.
